// File: rtl/xor_accum.sv
// xor_accum: frame-wise XOR fold of a valid/ready word stream into a checksum, parity, beat count and overflow flag.
// Optional build macro XOR_ACCUM_ROTATE_EN rotates the accumulator left by one before each fold (order-sensitive sum).
module xor_accum #(
  parameter  int WIDTH   = 16,
  parameter  int MAX_LEN = 256,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  typedef enum logic {S_ACCUM = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [CW-1:0] LP_MAX = CW'(MAX_LEN);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_close;

  // Shift form of the rotate degenerates to identity when WIDTH==1.
  function automatic logic [WIDTH-1:0] fold_f(input logic [WIDTH-1:0] a);
`ifdef XOR_ACCUM_ROTATE_EN
    return (a << 1) | (a >> (WIDTH - 1));
`else
    return a;
`endif
  endfunction

  assign w_accept  = in_valid && (r_state == S_ACCUM);
  assign w_acc_nxt = fold_f(r_acc) ^ in_data;
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_close   = in_last || (w_cnt_nxt == LP_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_close) begin
              r_ovf   <= !in_last;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_ACCUM;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  assign in_ready     = (r_state == S_ACCUM);
  assign out_valid    = (r_state == S_HOLD);
  assign out_sum      = r_acc;
  assign out_parity   = ^r_acc;
  assign out_count    = r_cnt;
  assign out_overflow = r_ovf;

endmodule

// File: tb/tb_xor_accum.sv
// Directed testbench for xor_accum: a MAX_LEN=256 instance for frame tests and a MAX_LEN=4 instance for overflow.
module tb_xor_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_parity, out_overflow;
  logic [15:0] out_sum;
  logic [8:0]  out_count;

  logic        in_valid4, in_last4, out_ready4;
  logic [15:0] in_data4;
  logic        in_ready4, out_valid4, out_parity4, out_overflow4;
  logic [15:0] out_sum4;
  logic [2:0]  out_count4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xor_accum #(.WIDTH(16), .MAX_LEN(256)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_parity(out_parity), .out_count(out_count), .out_overflow(out_overflow)
  );

  xor_accum #(.WIDTH(16), .MAX_LEN(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4),
    .out_parity(out_parity4), .out_count(out_count4), .out_overflow(out_overflow4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    in_valid = 1'b0; in_data = 16'hDEAD; in_last = 1'b0;
  endtask

  task automatic beat4(input logic [15:0] d, input logic last);
    in_valid4 = 1'b1; in_data4 = d; in_last4 = last;
    tick();
    in_valid4 = 1'b0; in_data4 = 16'hBEEF; in_last4 = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [15:0] sum, input logic par,
                              input logic [8:0] cnt);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sum"}, out_sum, sum);
    check({tag, "_par"}, out_parity, par);
    check({tag, "_cnt"}, out_count, cnt);
    check({tag, "_ovf"}, out_overflow, 1'b0);
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; out_ready4 = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; in_last4 = 1'b0;
    #1;
    tick(); tick();
    reset = 1'b0;

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", out_sum, 16'h0);
    check("rst_par", out_parity, 1'b0);
    check("rst_cnt", out_count, 9'd0);
    check("rst_ovf", out_overflow, 1'b0);

    // Three-beat frame, consumer always ready
    beat(16'h00FF, 1'b0);
    check("f3_mid_valid", out_valid, 1'b0);
    beat(16'h0F0F, 1'b0);
    beat(16'hFFFF, 1'b1);
    check_result("f3", 16'hF00F, 1'b0, 9'd3);
    check("f3_hold_ready", in_ready, 1'b0);
    tick();
    check("f3_ready_back", in_ready, 1'b1);
    check("f3_valid_drop", out_valid, 1'b0);

    // Single-beat frames; accumulator cleared between them
    beat(16'h0001, 1'b1);
    check_result("s1", 16'h0001, 1'b1, 9'd1);
    tick();
    beat(16'h0003, 1'b1);
    check_result("s2", 16'h0003, 1'b0, 9'd1);
    tick();

    // Backpressure: result held, input stalled
    out_ready = 1'b0;
    beat(16'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'(i * 16'h1111 + 16'h0101); in_last = i[0];
      check("bp_valid", out_valid, 1'b1);
      check("bp_sum", out_sum, 16'h1234);
      check("bp_cnt", out_count, 9'd1);
      check("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", in_ready, 1'b1);
    beat(16'h00F0, 1'b1);
    check_result("bp_next", 16'h00F0, 1'b0, 9'd1);
    tick();

    // Overflow at MAX_LEN=4 without last
    for (int i = 0; i < 4; i++) begin
      check("ov_pre_valid", out_valid4, 1'b0);
      beat4(16'h1111, 1'b0);
    end
    check("ov_valid", out_valid4, 1'b1);
    check("ov_sum", out_sum4, 16'h0000);
    check("ov_cnt", out_count4, 3'd4);
    check("ov_flag", out_overflow4, 1'b1);
    tick();
    check("ov_ready_back", in_ready4, 1'b1);
    check("ov_flag_clr", out_overflow4, 1'b0);
    for (int i = 0; i < 4; i++) beat4(16'h1111, (i == 3));
    check("ovl_valid", out_valid4, 1'b1);
    check("ovl_cnt", out_count4, 3'd4);
    check("ovl_flag", out_overflow4, 1'b0);
    tick();
    beat4(16'h0102, 1'b1);
    check("ov_short_cnt", out_count4, 3'd1);
    check("ov_short_sum", out_sum4, 16'h0102);
    tick();

    // Reset mid-frame discards partial state
    beat(16'hAAAA, 1'b0);
    beat(16'hAAAA, 1'b0);
    check("rm_cnt_pre", out_count, 9'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm_in_ready", in_ready, 1'b1);
    check("rm_out_valid", out_valid, 1'b0);
    check("rm_sum", out_sum, 16'h0);
    check("rm_cnt", out_count, 9'd0);
    beat(16'h5555, 1'b1);
    check_result("rm_next", 16'h5555, 1'b0, 9'd1);
    tick();

    // Reset while holding a result
    out_ready = 1'b0;
    beat(16'h0F00, 1'b1);
    check("rh_valid", out_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    check("rh_valid_clr", out_valid, 1'b0);
    check("rh_sum_clr", out_sum, 16'h0);

    // Order sensitivity depends on build configuration
    beat(16'h8000, 1'b0);
    beat(16'h0001, 1'b1);
`ifdef XOR_ACCUM_ROTATE_EN
    check_result("rot_a", 16'h0000, 1'b0, 9'd2);
`else
    check_result("rot_a", 16'h8001, 1'b0, 9'd2);
`endif
    tick();
    beat(16'h0001, 1'b0);
    beat(16'h8000, 1'b1);
`ifdef XOR_ACCUM_ROTATE_EN
    check_result("rot_b", 16'h8002, 1'b0, 9'd2);
`else
    check_result("rot_b", 16'h8001, 1'b0, 9'd2);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xor_accum.md
# xor_accum

Parametrised XOR-reduction engine, the sequential successor to the two-input `_xor` gate. It accepts a stream of WIDTH-bit words over a valid/ready handshake and XOR-folds every word of a frame into one accumulator. At frame end it presents the checksum word, its parity bit, the beat count and an overflow flag. It sits between word-stream producers and checkers as a checksum/parity stage in the gates-to-datapath layer.

## Interface
Parameters:
- WIDTH, 16, data word width (≥1).
- MAX_LEN, 256, maximum beats per frame (≥1); CW = $clog2(MAX_LEN+1).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  input word.
- in_last  input  1  final word of frame, qualified by in_valid.
- out_valid  output  1  frame result present.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  XOR of all frame words.
- out_parity  output  1  reduction XOR of out_sum.
- out_count  output  CW  beats in the frame (1..MAX_LEN).
- out_overflow  output  1  frame force-closed at MAX_LEN without in_last.

## Operation
- Two states: ACCUM and HOLD. Reset state: ACCUM.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid&&in_ready. On accept, acc <= f(acc) ^ in_data and cnt <= cnt+1. f is identity, or a rotate when so configured.
  - On an accepted beat with in_last=1, or with cnt+1==MAX_LEN:
    - acc and cnt keep the updated values.
    - overflow <= (in_last==0).
    - Next state HOLD.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_sum=acc, out_count=cnt, out_overflow=overflow, out_parity=^acc.
  - All outputs are held stable until out_ready=1.
  - On out_ready=1: acc<=0, cnt<=0, overflow<=0, next state ACCUM.
- in_data/in_last are ignored whenever the block is not accepting a beat.
- A beat that has both in_last=1 and cnt+1==MAX_LEN closes the frame with overflow=0.
- Arithmetic: acc is WIDTH bits; cnt is CW bits and never exceeds MAX_LEN, so it never wraps.
- There are no empty frames; a frame always contains ≥1 beat.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_parity=0, out_count=0, out_overflow=0. acc=0, cnt=0, state=ACCUM.
- Reset asserted in any state, including mid-frame or in HOLD, discards the partial frame and any pending result. The block is in reset values on the cycle after the edge at which reset is sampled. Reset has priority over all handshakes.
- Input throughput: 1 beat/cycle in ACCUM.
- Result latency: out_valid rises the cycle after the closing beat is accepted.
- Frame turnaround:
  - If out_ready is already high when out_valid rises, HOLD lasts exactly one cycle. in_ready returns the cycle after the result handshake.
  - A frame of L beats therefore takes at minimum L+1 cycles.
- All outputs are registered or decoded from state/registers only. There is no combinational in→out path; out_ready→in_ready is also registered.

## Configuration
- Macro: XOR_ACCUM_ROTATE_EN.
- Defined: f(acc) = acc rotated left by 1, so acc <= {acc[WIDTH-2:0],acc[WIDTH-1]} ^ in_data. This makes the checksum order-sensitive. When WIDTH==1 the rotate is identity.
- Undefined: f(acc)=acc, giving a plain order-insensitive XOR fold. No rotate logic is synthesised.
- Interface and timing are identical in both builds.

## Test plan
- Three-beat frame (WIDTH=16, MAX_LEN=256, macro off): beats 0x00FF, 0x0F0F, 0xFFFF with last on the third, out_ready=1 → one cycle later out_valid=1, out_sum=0xF00F, out_parity=0, out_count=3, out_overflow=0. in_ready=1 on the following cycle.
- Single-beat frame: 0x0001 with last → out_sum=0x0001, out_parity=1, out_count=1. Then frame 0x0003 with last → out_sum=0x0003; the accumulator was cleared between frames.
- Backpressure: complete a frame of 0x1234 (last), hold out_ready=0 for 5 cycles while in_valid=1 with varying data → out_valid, out_sum=0x1234 and out_count=1 stable; in_ready=0 throughout; no beats absorbed. After out_ready pulses, the next frame starts from acc=0.
- Overflow (MAX_LEN=4): four beats of 0x1111, in_last=0 → out_sum=0x0000, out_count=4, out_overflow=1. Repeating with in_last=1 on beat 4 → out_overflow=0.
- Reset mid-frame: two beats of 0xAAAA, then reset for 1 cycle → all outputs at reset values. Subsequent frame 0x5555 (last) → out_sum=0x5555, out_count=1.
- XOR_ACCUM_ROTATE_EN defined: beats 0x8000, 0x0001 (last) → out_sum=0x0000, out_count=2. Reversed order 0x0001, 0x8000 (last) → out_sum=0x8002.
